// File: rtl/sha256_iter_core_if.sv
// sha256_iter_core_if
//   Job/result bus of the SHA-256 iterative core.
//   Ports (signals):
//     in_valid     job offered by the dispatcher
//     in_ready     core idle; a job is taken on an edge where in_valid & in_ready
//     digest_init  feed-forward IV H0..H7, H0 in [255:224]
//     digest_in    working state a..h after START_ROUND rounds, a in [255:224]
//     block_in     message words W0..W15, W0 in [511:480]
//     out_valid    digest_out valid, held until taken
//     out_ready    consumer takes the result
//     digest_out   result, registered
//   Handshake: a transfer happens on a rising edge where valid & ready are both
//   high. The producer holds valid and its payload steady until that edge, and
//   valid never depends combinationally on ready.
//   Modports: master = dispatcher/consumer side, slave = core side.
interface sha256_iter_core_if;
   logic         in_valid;
   logic         in_ready;
   logic [255:0] digest_init;
   logic [255:0] digest_in;
   logic [511:0] block_in;
   logic         out_valid;
   logic         out_ready;
   logic [255:0] digest_out;

   modport master (
      output in_valid, digest_init, digest_in, block_in, out_ready,
      input  in_ready, out_valid, digest_out
   );

   modport slave (
      input  in_valid, digest_init, digest_in, block_in, out_ready,
      output in_ready, out_valid, digest_out
   );
endinterface

// File: rtl/sha256_iter_core.sv
// sha256_iter_core
//   SHA-256 compression core running UNROLL rounds per clock over a latched
//   512-bit block, optionally resuming from a mid-state that has already been
//   advanced START_ROUND rounds.
//   Parameters: UNROLL (1,2,4,8), START_ROUND (0..15, (64-START_ROUND)%UNROLL==0).
//   Ports:
//     CLK        rising-edge clock
//     RST        asynchronous, active-low reset
//     bus        sha256_iter_core_if.slave (job in, result out)
//     dbg_state  FSM state: 0 IDLE, 1 RUN, 2 DONE
//   Build option: SHA256_FEEDFORWARD_EN defined -> digest_out = a..h + digest_init
//   per word; undefined -> digest_out = raw a..h after round 63.
module sha256_iter_core #(
   parameter int UNROLL      = 1,
   parameter int START_ROUND = 0
) (
   input  logic                  CLK,
   input  logic                  RST,
   sha256_iter_core_if.slave     bus,
   output logic [1:0]            dbg_state
);

   if (!((UNROLL == 1) || (UNROLL == 2) || (UNROLL == 4) || (UNROLL == 8)) ||
       (START_ROUND < 0) || (START_ROUND > 15) ||
       (((64 - START_ROUND) % UNROLL) != 0)) begin : g_param_check
      $error("sha256_iter_core: illegal UNROLL/START_ROUND combination");
   end

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [31:0] K_ROM [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [31:0] small_s0(input logic [31:0] x);
      return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
   endfunction

   function automatic logic [31:0] small_s1(input logic [31:0] x);
      return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
   endfunction

   // Message window: element 0 is W[t]. One step consumes W[t] and appends
   // W[t+16] = s1(W[t+14]) + W[t+9] + s0(W[t+1]) + W[t].
   function automatic logic [15:0][31:0] w_step(input logic [15:0][31:0] w);
      logic [31:0] w_new;
      w_new = small_s1(w[14]) + w[9] + small_s0(w[1]) + w[0];
      return {w_new, w[15:1]};
   endfunction

   // One compression round over packed a..h (a in [255:224]).
   function automatic logic [255:0] sha_round(input logic [255:0] s, input logic [31:0] k,
                                              input logic [31:0] w);
      logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
      {a, b, c, d, e, f, g, h} = s;
      t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + k + w;
      t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      return {t1 + t2, a, b, c, d + t1, e, f, g};
   endfunction

   state_t             state_q, state_d;
   logic [6:0]         t_q, t_d;
   logic [15:0][31:0]  w_q, w_d;
   logic [255:0]       s_q, s_d;
   logic               out_valid_q, out_valid_d;
   logic [255:0]       digest_q, digest_d;
`ifdef SHA256_FEEDFORWARD_EN
   logic [255:0]       iv_q, iv_d;
`else
   // The IV is not needed when the caller performs the feed-forward add.
   logic               unused_digest_init;
   assign unused_digest_init = ^bus.digest_init;
`endif

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q     <= IDLE;
         t_q         <= '0;
         w_q         <= '0;
         s_q         <= '0;
         out_valid_q <= 1'b0;
         digest_q    <= '0;
`ifdef SHA256_FEEDFORWARD_EN
         iv_q        <= '0;
`endif
      end else begin
         state_q     <= state_d;
         t_q         <= t_d;
         w_q         <= w_d;
         s_q         <= s_d;
         out_valid_q <= out_valid_d;
         digest_q    <= digest_d;
`ifdef SHA256_FEEDFORWARD_EN
         iv_q        <= iv_d;
`endif
      end
   end

   always_comb begin : next_state_logic
      logic [15:0][31:0] win;
      logic [15:0][31:0] init_win;
      logic [255:0]      rs;
      logic [5:0]        kidx;

      state_d     = state_q;
      t_d         = t_q;
      w_d         = w_q;
      s_d         = s_q;
      out_valid_d = out_valid_q;
      digest_d    = digest_q;
`ifdef SHA256_FEEDFORWARD_EN
      iv_d        = iv_q;
`endif

      // UNROLL chained rounds t..t+UNROLL-1 from the registered state.
      win  = w_q;
      rs   = s_q;
      kidx = '0;
      for (int u = 0; u < UNROLL; u++) begin
         kidx = t_q[5:0] + 6'(u);
         rs   = sha_round(rs, K_ROM[kidx], win[0]);
         win  = w_step(win);
      end

      // A resumed job starts with the window already slid to W[START_ROUND].
      for (int i = 0; i < 16; i++) begin
         init_win[i] = bus.block_in[511 - 32*i -: 32];
      end
      for (int i = 0; i < START_ROUND; i++) begin
         init_win = w_step(init_win);
      end

      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               state_d = RUN;
               t_d     = 7'(START_ROUND);
               w_d     = init_win;
               s_d     = bus.digest_in;
`ifdef SHA256_FEEDFORWARD_EN
               iv_d    = bus.digest_init;
`endif
            end
         end
         RUN: begin
            s_d = rs;
            w_d = win;
            t_d = t_q + 7'(UNROLL);
            if (t_q + 7'(UNROLL) == 7'd64) begin
               state_d     = DONE;
               out_valid_d = 1'b1;
`ifdef SHA256_FEEDFORWARD_EN
               for (int i = 0; i < 8; i++) begin
                  digest_d[32*i +: 32] = rs[32*i +: 32] + iv_q[32*i +: 32];
               end
`else
               digest_d = rs;
`endif
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               state_d     = IDLE;
               out_valid_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.in_ready   = (state_q == IDLE);
   assign bus.out_valid  = out_valid_q;
   assign bus.digest_out = digest_q;
   assign dbg_state      = state_q;

endmodule

// File: tb/tb_sha256_iter_core.sv
module tb_sha256_iter_core;

   localparam logic [255:0] IV = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
   localparam logic [511:0] ABC_BLK = 512'h61626380_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000018;
   localparam logic [511:0] EMPTY_BLK = 512'h80000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000;
   localparam logic [255:0] ABC_D = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
   localparam logic [255:0] EMPTY_D = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;

   // ---------------- clock / reset ----------------
   logic CLK = 1'b0;
   logic RST;
   always #5 CLK = ~CLK;

   // ---------------- DUT hookup ----------------
   // index 0: UNROLL=1 START_ROUND=0, 1: UNROLL=4 START_ROUND=0, 2: UNROLL=2 START_ROUND=4
   logic [2:0]        iv_valid;
   logic [2:0]        ov_ready;
   logic [2:0][255:0] iv_init;
   logic [2:0][255:0] iv_in;
   logic [2:0][511:0] iv_blk;
   wire  [2:0]        in_rdy;
   wire  [2:0]        ov_valid;
   wire  [2:0][255:0] ov_data;
   wire  [2:0][1:0]   dbg;

   sha256_iter_core_if bus0 ();
   sha256_iter_core_if bus1 ();
   sha256_iter_core_if bus2 ();

   assign bus0.in_valid    = iv_valid[0];
   assign bus0.digest_init = iv_init[0];
   assign bus0.digest_in   = iv_in[0];
   assign bus0.block_in    = iv_blk[0];
   assign bus0.out_ready   = ov_ready[0];
   assign in_rdy[0]        = bus0.in_ready;
   assign ov_valid[0]      = bus0.out_valid;
   assign ov_data[0]       = bus0.digest_out;

   assign bus1.in_valid    = iv_valid[1];
   assign bus1.digest_init = iv_init[1];
   assign bus1.digest_in   = iv_in[1];
   assign bus1.block_in    = iv_blk[1];
   assign bus1.out_ready   = ov_ready[1];
   assign in_rdy[1]        = bus1.in_ready;
   assign ov_valid[1]      = bus1.out_valid;
   assign ov_data[1]       = bus1.digest_out;

   assign bus2.in_valid    = iv_valid[2];
   assign bus2.digest_init = iv_init[2];
   assign bus2.digest_in   = iv_in[2];
   assign bus2.block_in    = iv_blk[2];
   assign bus2.out_ready   = ov_ready[2];
   assign in_rdy[2]        = bus2.in_ready;
   assign ov_valid[2]      = bus2.out_valid;
   assign ov_data[2]       = bus2.digest_out;

   sha256_iter_core #(.UNROLL(1), .START_ROUND(0)) dut_u1 (.CLK(CLK), .RST(RST), .bus(bus0), .dbg_state(dbg[0]));
   sha256_iter_core #(.UNROLL(4), .START_ROUND(0)) dut_u4 (.CLK(CLK), .RST(RST), .bus(bus1), .dbg_state(dbg[1]));
   sha256_iter_core #(.UNROLL(2), .START_ROUND(4)) dut_mid (.CLK(CLK), .RST(RST), .bus(bus2), .dbg_state(dbg[2]));

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_fail   = 0;
   logic [255:0] exp_q[$];

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Turn the core output into a chaining value (adds the IV when the core
   // leaves the feed-forward to the caller).
   function automatic logic [255:0] chain(input logic [255:0] d, input logic [255:0] iv);
      logic [255:0] r;
`ifdef SHA256_FEEDFORWARD_EN
      r = d;
`else
      for (int i = 0; i < 8; i++) begin
         r[32*i +: 32] = d[32*i +: 32] + iv[32*i +: 32];
      end
`endif
      return r;
   endfunction

   // Reference for the midstate: first four rounds of "abc" from the IV.
   function automatic logic [31:0] rr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [255:0] mid4(input logic [255:0] s, input logic [511:0] blk);
      logic [31:0] a, b, c, d, e, f, g, h, t1, t2, w;
      logic [31:0] k [4];
      k[0] = 32'h428a2f98; k[1] = 32'h71374491; k[2] = 32'hb5c0fbcf; k[3] = 32'he9b5dba5;
      {a, b, c, d, e, f, g, h} = s;
      for (int r = 0; r < 4; r++) begin
         w  = blk[511 - 32*r -: 32];
         t1 = h + (rr(e, 6) ^ rr(e, 11) ^ rr(e, 25)) + ((e & f) ^ (~e & g)) + k[r] + w;
         t2 = (rr(a, 2) ^ rr(a, 13) ^ rr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
         h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
      end
      return {a, b, c, d, e, f, g, h};
   endfunction

   // ---------------- driver ----------------
   // Offers one job to core s, scrambles the inputs right after the accept
   // edge, then counts edges until out_valid and checks latency and digest.
   task automatic run_job(input int s, input logic [255:0] init, input logic [255:0] din,
                          input logic [511:0] blk, input int exp_lat, input string tag);
      int waitc;
      int lat;
      logic [255:0] exp_d;
      waitc = 0;
      while (!in_rdy[s] && waitc < 100) begin
         @(posedge CLK); #1;
         waitc++;
      end
      check({tag, "_in_ready"}, 256'(in_rdy[s]), 256'd1);
      iv_init[s]  = init;
      iv_in[s]    = din;
      iv_blk[s]   = blk;
      iv_valid[s] = 1'b1;
      @(posedge CLK); #1;
      iv_valid[s] = 1'b0;
      iv_init[s]  = {8{$urandom()}};
      iv_in[s]    = {8{$urandom()}};
      iv_blk[s]   = {16{$urandom()}};
      lat = 0;
      do begin
         @(posedge CLK); #1;
         lat++;
      end while (!ov_valid[s] && lat < 200);
      check({tag, "_latency"}, 256'(lat), 256'(exp_lat));
      exp_d = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
      check({tag, "_digest"}, chain(ov_data[s], init), exp_d);
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      int lat;
      int pulses;
      RST      = 1'b0;
      iv_valid = '0;
      ov_ready = '1;
      iv_init  = '0;
      iv_in    = '0;
      iv_blk   = '0;

      repeat (3) @(posedge CLK);
      #1;
      for (int s = 0; s < 3; s++) begin
         check("rst_in_ready",  256'(in_rdy[s]),   256'd1);
         check("rst_out_valid", 256'(ov_valid[s]), 256'd0);
         check("rst_digest",    ov_data[s],        256'd0);
         check("rst_state",     256'(dbg[s]),      256'd0);
      end
      @(negedge CLK);
      RST = 1'b1;
      @(posedge CLK); #1;

      // "abc", one round per clock
      exp_q.push_back(ABC_D);
      run_job(0, IV, IV, ABC_BLK, 64, "t1_abc");
      @(posedge CLK); #1;
      check("t1_back_idle",  256'(in_rdy[0]),   256'd1);
      check("t1_valid_drop", 256'(ov_valid[0]), 256'd0);
      check("t1_digest_kept", chain(ov_data[0], IV), ABC_D);

      // empty message, four rounds per clock
      exp_q.push_back(EMPTY_D);
      run_job(1, IV, IV, EMPTY_BLK, 16, "t2_empty");

      // resume from a 4-round midstate, two rounds per clock
      exp_q.push_back(ABC_D);
      run_job(2, IV, mid4(IV, ABC_BLK), ABC_BLK, 30, "t3_mid");

      // backpressure in DONE while a new job is offered
      ov_ready[1] = 1'b0;
      exp_q.push_back(EMPTY_D);
      run_job(1, IV, IV, EMPTY_BLK, 16, "t4_bp");
      iv_init[1]  = IV;
      iv_in[1]    = IV;
      iv_blk[1]   = ABC_BLK;
      iv_valid[1] = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge CLK); #1;
         check("t4_hold_valid",  256'(ov_valid[1]), 256'd1);
         check("t4_hold_digest", chain(ov_data[1], IV), EMPTY_D);
         check("t4_hold_in_rdy", 256'(in_rdy[1]), 256'd0);
         check("t4_hold_state",  256'(dbg[1]), 256'd2);
      end
      ov_ready[1] = 1'b1;
      @(posedge CLK); #1;
      check("t4_rel_valid",  256'(ov_valid[1]), 256'd0);
      check("t4_rel_in_rdy", 256'(in_rdy[1]), 256'd1);
      check("t4_rel_digest", chain(ov_data[1], IV), EMPTY_D);
      @(posedge CLK); #1;
      check("t4_accept_state", 256'(dbg[1]), 256'd1);
      iv_valid[1] = 1'b0;
      iv_blk[1]   = {16{$urandom()}};
      lat = 0;
      do begin
         @(posedge CLK); #1;
         lat++;
      end while (!ov_valid[1] && lat < 200);
      check("t4_next_latency", 256'(lat), 256'd16);
      check("t4_next_digest", chain(ov_data[1], IV), ABC_D);

      // reset in the middle of an "abc" job on the one-round core
      iv_init[0]  = IV;
      iv_in[0]    = IV;
      iv_blk[0]   = ABC_BLK;
      iv_valid[0] = 1'b1;
      @(posedge CLK); #1;
      iv_valid[0] = 1'b0;
      repeat (20) @(posedge CLK);
      #1;
      check("t5_running", 256'(dbg[0]), 256'd1);
      RST = 1'b0;
      #2;
      check("t5_rst_valid",  256'(ov_valid[0]), 256'd0);
      check("t5_rst_digest", ov_data[0],        256'd0);
      check("t5_rst_in_rdy", 256'(in_rdy[0]),   256'd1);
      check("t5_rst_state",  256'(dbg[0]),      256'd0);
      @(negedge CLK);
      RST = 1'b1;
      pulses = 0;
      for (int i = 0; i < 70; i++) begin
         @(posedge CLK); #1;
         if (ov_valid[0]) pulses++;
      end
      check("t5_no_pulse", 256'(pulses), 256'd0);
      exp_q.push_back(EMPTY_D);
      run_job(1, IV, IV, EMPTY_BLK, 16, "t5_rerun");

      check("sb_drained", 256'(exp_q.size()), 256'd0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
